// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and sizing helpers for the UART frame codec
package uart_pkg;

    localparam logic [7:0] DEFAULT_SYNC        = 8'hA5;
    localparam int         CLK_HZ              = 50_000_000;
    // 4 ms of silence at 50 MHz: several byte times even at slow baud rates
    localparam int         DEFAULT_TIMEOUT_CYC = CLK_HZ / 250;

    typedef enum logic [1:0] {RX_HUNT, RX_PAYLOAD, RX_CHECK} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GUARD, TX_WAIT} tx_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int idx_w(input int v);
        return (v <= 1) ? 1 : clog2(v);
    endfunction

    function automatic int bpe(input int n);
        return n / 8;
    endfunction

    function automatic int nb(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_frame_codec_if.sv
// rtl/uart_frame_codec_if.sv - byte link between the codec and the async receiver/transmitter pair
interface uart_frame_codec_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (input rx_valid, rx_data, tx_busy, output tx_start, tx_data);
    modport slave  (output rx_valid, rx_data, tx_busy, input tx_start, tx_data);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO with fall-through read data
module sync_fifo import uart_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Extra pointer bit distinguishes full from empty when the indices match
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/uart_frame_codec.sv
// rtl/uart_frame_codec.sv - SYNC/payload/XOR frame decoder and queued result serialiser
module uart_frame_codec import uart_pkg::*; #(
    parameter int         N           = 32,
    parameter int         NH          = 16,
    parameter int         NY          = 8,
    parameter logic [7:0] SYNC        = DEFAULT_SYNC,
    parameter int         TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int         MSG_W       = 12,
    parameter int         MSG_DEPTH   = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     rst_p,
    uart_frame_codec_if.master       link,
    output logic                     sys_start,
    output logic                     H_valid,
    output logic [N-1:0]             H_r,
    output logic [N-1:0]             H_i,
    output logic [idx_w(NH)-1:0]     H_idx,
    output logic                     Y_valid,
    output logic [N-1:0]             Y_r,
    output logic [N-1:0]             Y_i,
    output logic [idx_w(NY)-1:0]     Y_idx,
    output logic                     frame_done,
    output logic                     frame_err,
    input  logic [MSG_W-1:0]         message,
    input  logic                     message_ready,
    output logic                     msg_full,
    output logic                     msg_overflow
);
    localparam int EB  = 2 * bpe(N);
    localparam int BW  = idx_w(EB);
    localparam int NE  = NH + NY;
    localparam int EW  = idx_w(NE);
    localparam int HW  = idx_w(NH);
    localparam int YW  = idx_w(NY);
    localparam int NBY = nb(MSG_W);
    localparam int SW  = 8 * NBY;

    rx_state_t      rx_state, rx_next;
    logic [BW-1:0]  byte_cnt;
    logic [EW-1:0]  elem_cnt;
    logic [2*N-9:0] asm_q;
    logic [2*N-1:0] elem_word;
    logic [7:0]     chk_acc;
    logic [31:0]    idle_cnt;
    logic           rx_timeout, elem_end, last_elem, sync_hit;

    assign sync_hit   = link.rx_valid && (link.rx_data == SYNC);
    assign elem_end   = (byte_cnt == BW'(EB - 1));
    assign last_elem  = (elem_cnt == EW'(NE - 1));
    assign rx_timeout = (rx_state != RX_HUNT) && !link.rx_valid
                        && (idle_cnt == 32'(TIMEOUT_CYC - 1));
    // The final byte is merged straight in so the element leaves one cycle after it arrives
    assign elem_word  = {asm_q, link.rx_data};

    always_ff @(posedge CLOCK_50 or posedge rst_p) begin
        if (rst_p) rx_state <= RX_HUNT;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_HUNT:    if (sync_hit) rx_next = RX_PAYLOAD;
            RX_PAYLOAD: if (rx_timeout) rx_next = RX_HUNT;
                        else if (link.rx_valid && elem_end && last_elem) rx_next = RX_CHECK;
            RX_CHECK:   if (rx_timeout || link.rx_valid) rx_next = RX_HUNT;
            default:    rx_next = RX_HUNT;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge rst_p) begin
        if (rst_p) begin
            byte_cnt <= '0; elem_cnt <= '0; asm_q <= '0; chk_acc <= '0; idle_cnt <= '0;
            sys_start <= 1'b0; H_valid <= 1'b0; Y_valid <= 1'b0;
            frame_done <= 1'b0; frame_err <= 1'b0;
            H_r <= '0; H_i <= '0; H_idx <= '0; Y_r <= '0; Y_i <= '0; Y_idx <= '0;
        end else begin
            sys_start  <= 1'b0;
            H_valid    <= 1'b0;
            Y_valid    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= rx_timeout;
            idle_cnt   <= (link.rx_valid || rx_state == RX_HUNT) ? '0 : idle_cnt + 1'b1;
            case (rx_state)
                RX_HUNT: if (sync_hit) begin
                    byte_cnt  <= '0;
                    elem_cnt  <= '0;
                    chk_acc   <= '0;
                    sys_start <= 1'b1;
                end
                RX_PAYLOAD: if (link.rx_valid) begin
                    asm_q   <= elem_word[2*N-9:0];
                    chk_acc <= chk_acc ^ link.rx_data;
                    if (elem_end) begin
                        byte_cnt <= '0;
                        elem_cnt <= elem_cnt + 1'b1;
                        if (elem_cnt < EW'(NH)) begin
                            H_valid <= 1'b1;
                            H_r     <= elem_word[2*N-1:N];
                            H_i     <= elem_word[N-1:0];
                            H_idx   <= HW'(elem_cnt);
                        end else begin
                            Y_valid <= 1'b1;
                            Y_r     <= elem_word[2*N-1:N];
                            Y_i     <= elem_word[N-1:0];
                            Y_idx   <= YW'(elem_cnt - EW'(NH));
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                RX_CHECK: if (link.rx_valid) begin
                    frame_done <= (chk_acc == link.rx_data);
                    frame_err  <= (chk_acc != link.rx_data);
                end
                default: ;
            endcase
        end
    end

    tx_state_t       tx_state, tx_next;
    logic [SW-1:0]   tx_sh;
    logic [2:0]      tx_cnt;
    logic [MSG_W-1:0] fifo_rd_data;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;

    assign fifo_pop  = (tx_state == TX_IDLE) && !fifo_empty && !link.tx_busy;
    assign fifo_push = message_ready && (!fifo_full || fifo_pop);
    assign msg_full  = fifo_full;

    sync_fifo #(.WIDTH(MSG_W), .DEPTH(MSG_DEPTH)) u_msg_fifo (
        .clk     (CLOCK_50),
        .rst     (rst_p),
        .wr_en   (fifo_push),
        .wr_data (message),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge CLOCK_50 or posedge rst_p) begin
        if (rst_p) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // GUARD is the first WAIT cycle, where tx_busy may not have risen yet
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (fifo_pop) tx_next = TX_SEND;
            TX_SEND:  tx_next = TX_GUARD;
            TX_GUARD: tx_next = TX_WAIT;
            TX_WAIT:  if (!link.tx_busy) tx_next = (tx_cnt > 3'd1) ? TX_SEND : TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge rst_p) begin
        if (rst_p) begin
            tx_sh        <= '0;
            tx_cnt       <= '0;
            msg_overflow <= 1'b0;
        end else begin
            if (message_ready && fifo_full && !fifo_pop) msg_overflow <= 1'b1;
            if (fifo_pop) begin
                tx_sh  <= SW'(fifo_rd_data);
                tx_cnt <= 3'(NBY);
            end else if (tx_state == TX_WAIT && !link.tx_busy) begin
                tx_sh  <= tx_sh << 8;
                tx_cnt <= tx_cnt - 1'b1;
            end
        end
    end

    assign link.tx_start = (tx_state == TX_SEND);
    assign link.tx_data  = tx_sh[SW-1 -: 8];
endmodule
